mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access (MEM) stage controller sitting directly upstream of the 16-bit, word-addressed data memory (SRAM with active-low write enable and a shared tri-state data bus). It accepts load/store requests from the EX/MEM pipeline register over a valid/ready handshake. It converts byte addresses to word addresses and drives the memory bus. Byte stores are performed as a two-cycle read-modify-write; load/store results are registered into a single-entry output slot feeding the MEM/WB stage.

## Interface
- DATA_WIDTH, 16, memory word width; fixed at 16 (byte lanes assume two bytes/word)
- ADX_LENGTH, 11, memory word-address width; byte address is ADX_LENGTH+1 bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted on a rising edge where in_valid && in_ready
- in_op  in  2  00 load word, 01 load byte (sign-extend), 10 store word, 11 store byte
- in_addr  in  ADX_LENGTH+1  byte address; bit 0 = byte lane (0 → bits 7:0, 1 → bits 15:8)
- in_wdata  in  16  store data; store byte uses in_wdata[7:0]
- in_rd  in  3  destination register tag, passed through
- out_valid  out  1  result slot full
- out_ready  in  1  consumer takes slot on edge where out_valid && out_ready
- out_rdata  out  16  load result (0 for stores)
- out_rd  out  3  tag of the retired request
- out_is_load  out  1  1 = load result, 0 = store completion
- mem_adx  out  ADX_LENGTH  word address to memory
- mem_WrEn  out  1  memory write enable, active-low
- mem_data  inout  16  shared data bus; driven only while mem_WrEn = 0, else high-Z

## Operation
- States: IDLE, RMW_WR.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- IDLE: mem_adx = in_addr[ADX_LENGTH:1]; mem_WrEn = 0 only when accepting a store word, else 1.
- Load word: accept edge captures mem_data into out_rdata.
- Load byte: accept edge captures the selected lane, sign-extended to 16 bits.
- Store word: mem_WrEn = 0 and mem_data = in_wdata during the accept cycle; the memory writes at that edge. The slot is filled with out_is_load = 0 and out_rdata = 0.
- Store byte: on the accept cycle, read the word (mem_WrEn = 1). At the accept edge, latch the merged word (the new byte replaces the selected lane, the other lane is preserved), the word address and in_rd, then go to RMW_WR.
- RMW_WR: mem_adx = latched address, mem_WrEn = 0, mem_data = merged word, in_ready = 0. At the next edge the memory writes, the slot is filled (out_is_load = 0) and the state returns to IDLE. The slot is guaranteed empty-or-draining here because acceptance required it.
- Output slot: set on completion, cleared on the out_ready handshake; simultaneous clear and fill in the same edge results in fill.
- Bus contention: mem_data is high-Z whenever mem_WrEn = 1; the block never drives while the memory drives.
- Reset (asserted asynchronously, any state): state = IDLE, out_valid = 0, out_rdata = 0, out_rd = 0, out_is_load = 0, mem_WrEn = 1 immediately, mem_data high-Z. A byte store interrupted in RMW_WR is dropped and memory is unchanged.

## Timing
- Load/store word: 1-cycle occupancy; out_valid rises the edge after acceptance. Throughput 1 request/cycle when out_ready is held at 1.
- Store byte: 2-cycle occupancy; out_valid rises 2 edges after acceptance; in_ready = 0 in the second cycle.
- Back-to-back load after a store to the same address (word or byte) returns the new data, because the write completes at the edge before the load's accept cycle.
- Backpressure: out_valid && !out_ready forces in_ready = 0; no request is lost or duplicated.

## Structure
- Package mem_pkg: op encodings (OP_LW, OP_LB, OP_SW, OP_SB), state enum, DATA_WIDTH / ADX_LENGTH constants.
- Sub-module byte_lane_unit (combinational): lane extract with sign extension for loads, and lane merge for stores. Instantiated once for each function.
- Top module holds the FSM, the RMW holding registers, the output slot and the tri-state driver.

## Test plan
- Reset, then store word 0xBEEF to byte addr 0x010, then load word from 0x010 → out_rdata = 0xBEEF, out_is_load = 1, mem_adx = 0x008 during both accesses.
- Memory word 0x008 = 0x1234; store byte 0xAB to addr 0x011 → memory 0xAB34. Check that mem_WrEn is low only in the second cycle and that in_ready = 0 in that cycle.
- Memory word = 0x80F0; load byte at addr 0x010 → out_rdata = 0xFFF0; load byte at addr 0x011 → out_rdata = 0xFF80.
- Hold out_ready = 0 with out_valid = 1 and present a load → in_ready = 0 and no acceptance. Release out_ready → load is accepted and the result appears the next cycle with the correct out_rd.
- Assert rst while in RMW_WR → mem_WrEn goes to 1 asynchronously, target word unchanged, out_valid = 0 after reset.
- Random stream of 200 mixed ops with random out_ready stalls, checked against a scoreboard: in-order out_rd sequence, and no mem_data drive while mem_WrEn = 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, opcode and FSM encodings for the MEM stage controller.
package mem_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADX_LENGTH = 11;

    typedef enum logic [1:0] {
        OP_LW = 2'b00,
        OP_LB = 2'b01,
        OP_SW = 2'b10,
        OP_SB = 2'b11
    } op_e;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    // Sign-extend one byte to a full memory word.
    function automatic logic [DATA_WIDTH-1:0] sext_byte(input logic [7:0] b);
        return {{(DATA_WIDTH - 8){b[7]}}, b};
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane helper: extracts a sign-extended lane for loads, or merges a new
// byte into the selected lane (keeping the other lane) for stores.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  lane_i,
    input  logic [7:0]            byte_i,
    input  logic                  merge_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [7:0] lane_byte;

    // Lane select, then either sign-extend it or replace it with byte_i.
    always_comb begin
        lane_byte = lane_i ? word_i[15:8] : word_i[7:0];
        if (merge_i) begin
            result_o = lane_i ? {byte_i, word_i[7:0]} : {word_i[15:8], byte_i};
        end else begin
            result_o = sext_byte(lane_byte);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage controller: accepts load/store requests, drives the word-addressed
// SRAM bus (active-low write enable, shared tri-state data), performs byte
// stores as a read-modify-write and holds each result in a one-entry slot.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [ADX_LENGTH:0]   in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic [2:0]            in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic [2:0]            out_rd,
    output logic                  out_is_load,
    output logic [ADX_LENGTH-1:0] mem_adx,
    output logic                  mem_WrEn,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    state_e                state_q, state_d;
    logic [ADX_LENGTH-1:0] rmw_adx_q, rmw_adx_d;
    logic [DATA_WIDTH-1:0] rmw_word_q, rmw_word_d;
    logic [2:0]            rmw_rd_q, rmw_rd_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_rdata_q, out_rdata_d;
    logic [2:0]            out_rd_q, out_rd_d;
    logic                  out_is_load_q, out_is_load_d;

    op_e                   op;
    logic                  accept;
    logic                  drv_en;
    logic [DATA_WIDTH-1:0] drv_data;
    logic [DATA_WIDTH-1:0] bus_rd;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged_word;

    assign op     = op_e'(in_op);
    assign bus_rd = mem_data;

    // Gating with rst keeps the bus released while reset is held, even if a
    // store word is presented during reset.
    assign in_ready = rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    byte_lane_unit u_load_lane (
        .word_i   (bus_rd),
        .lane_i   (in_addr[0]),
        .byte_i   (in_wdata[7:0]),
        .merge_i  (1'b0),
        .result_o (load_ext)
    );

    byte_lane_unit u_store_lane (
        .word_i   (bus_rd),
        .lane_i   (in_addr[0]),
        .byte_i   (in_wdata[7:0]),
        .merge_i  (1'b1),
        .result_o (merged_word)
    );

    // Next-state, RMW latch, result slot and memory bus control.
    always_comb begin
        state_d       = state_q;
        rmw_adx_d     = rmw_adx_q;
        rmw_word_d    = rmw_word_q;
        rmw_rd_d      = rmw_rd_q;
        out_valid_d   = out_valid_q;
        out_rdata_d   = out_rdata_q;
        out_rd_d      = out_rd_q;
        out_is_load_d = out_is_load_q;
        mem_adx       = in_addr[ADX_LENGTH:1];
        drv_en        = 1'b0;
        drv_data      = in_wdata;

        // Drain first; a fill later in this block overrides the clear.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LW: begin
                            out_valid_d   = 1'b1;
                            out_rdata_d   = bus_rd;
                            out_rd_d      = in_rd;
                            out_is_load_d = 1'b1;
                        end
                        OP_LB: begin
                            out_valid_d   = 1'b1;
                            out_rdata_d   = load_ext;
                            out_rd_d      = in_rd;
                            out_is_load_d = 1'b1;
                        end
                        OP_SW: begin
                            drv_en        = 1'b1;
                            out_valid_d   = 1'b1;
                            out_rdata_d   = '0;
                            out_rd_d      = in_rd;
                            out_is_load_d = 1'b0;
                        end
                        OP_SB: begin
                            rmw_adx_d  = in_addr[ADX_LENGTH:1];
                            rmw_word_d = merged_word;
                            rmw_rd_d   = in_rd;
                            state_d    = RMW_WR;
                        end
                        default: ;
                    endcase
                end
            end
            RMW_WR: begin
                mem_adx       = rmw_adx_q;
                drv_en        = 1'b1;
                drv_data      = rmw_word_q;
                out_valid_d   = 1'b1;
                out_rdata_d   = '0;
                out_rd_d      = rmw_rd_q;
                out_is_load_d = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, RMW holding registers and result slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rmw_adx_q     <= '0;
            rmw_word_q    <= '0;
            rmw_rd_q      <= '0;
            out_valid_q   <= 1'b0;
            out_rdata_q   <= '0;
            out_rd_q      <= '0;
            out_is_load_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rmw_adx_q     <= rmw_adx_d;
            rmw_word_q    <= rmw_word_d;
            rmw_rd_q      <= rmw_rd_d;
            out_valid_q   <= out_valid_d;
            out_rdata_q   <= out_rdata_d;
            out_rd_q      <= out_rd_d;
            out_is_load_q <= out_is_load_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rdata   = out_rdata_q;
    assign out_rd      = out_rd_q;
    assign out_is_load = out_is_load_q;

    assign mem_WrEn = ~drv_en;
    assign mem_data = drv_en ? drv_data : 'z;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: SRAM model on the tri-state bus, directed cases
// with literal expectations, then a randomized stream against a reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [11:0] in_addr;
    logic [15:0] in_wdata;
    logic [2:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_rdata;
    logic [2:0]  out_rd;
    logic        out_is_load;
    logic [10:0] mem_adx;
    logic        mem_WrEn;
    wire  [15:0] mem_data;

    mem_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rdata   (out_rdata),
        .out_rd      (out_rd),
        .out_is_load (out_is_load),
        .mem_adx     (mem_adx),
        .mem_WrEn    (mem_WrEn),
        .mem_data    (mem_data)
    );

    always #5 clk = ~clk;

    // SRAM: asynchronous read onto the bus when not writing, write on the edge.
    logic [15:0] mem_arr [2048];
    logic        mem_clear;
    assign mem_data = mem_WrEn ? mem_arr[mem_adx] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 2048; i++) mem_arr[i] <= '0;
        end else if (!mem_WrEn) begin
            mem_arr[mem_adx] <= mem_data;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image, in-order result queue, pending byte store.
    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        logic        is_load;
    } res_t;

    res_t        expq[$];
    res_t        r;
    logic [15:0] mdl_mem [2048];
    bit          mdl_init = 0;
    bit          sb_busy  = 0;
    logic [10:0] sb_wadx;
    logic        sb_lane;
    logic [7:0]  sb_byte;
    logic [2:0]  sb_rd;
    logic [15:0] word;
    logic [10:0] wadx;
    logic [7:0]  b;
    bit          exp_ready;

    int          pops = 0;
    logic [15:0] last_rdata;
    logic [2:0]  last_rd;
    logic        last_is_load;
    logic        acc_wren;
    logic [10:0] acc_adx;

    always @(negedge clk) begin
        if (!mdl_init) begin
            for (int i = 0; i < 2048; i++) mdl_mem[i] = '0;
            mdl_init = 1;
        end
        if (!rst) begin
            expq.delete();
            sb_busy = 0;
        end else begin
            exp_ready = !sb_busy && (expq.size() == 0 || out_ready);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, expq.size() != 0);
            if (mem_WrEn) chk("bus_idle_data", mem_data, mem_arr[mem_adx]);

            if (out_valid && out_ready && expq.size() != 0) begin
                r = expq.pop_front();
                chk("out_rd", out_rd, r.rd);
                chk("out_rdata", out_rdata, r.data);
                chk("out_is_load", out_is_load, r.is_load);
                last_rdata   = out_rdata;
                last_rd      = out_rd;
                last_is_load = out_is_load;
                pops++;
            end

            if (sb_busy) begin
                word = mdl_mem[sb_wadx];
                if (sb_lane) word[15:8] = sb_byte;
                else         word[7:0]  = sb_byte;
                chk("rmw_wren", mem_WrEn, 1'b0);
                chk("rmw_adx", mem_adx, sb_wadx);
                chk("rmw_data", mem_data, word);
                mdl_mem[sb_wadx] = word;
                expq.push_back('{sb_rd, 16'h0000, 1'b0});
                sb_busy = 0;
            end else if (in_valid && exp_ready) begin
                wadx = in_addr[11:1];
                chk("acc_adx", mem_adx, wadx);
                acc_adx  = mem_adx;
                acc_wren = mem_WrEn;
                case (in_op)
                    2'b00: begin
                        chk("lw_wren", mem_WrEn, 1'b1);
                        expq.push_back('{in_rd, mdl_mem[wadx], 1'b1});
                    end
                    2'b01: begin
                        chk("lb_wren", mem_WrEn, 1'b1);
                        word = mdl_mem[wadx];
                        b = in_addr[0] ? word[15:8] : word[7:0];
                        expq.push_back('{in_rd, {{8{b[7]}}, b}, 1'b1});
                    end
                    2'b10: begin
                        chk("sw_wren", mem_WrEn, 1'b0);
                        chk("sw_data", mem_data, in_wdata);
                        mdl_mem[wadx] = in_wdata;
                        expq.push_back('{in_rd, 16'h0000, 1'b0});
                    end
                    default: begin
                        chk("sb_read_wren", mem_WrEn, 1'b1);
                        sb_busy = 1;
                        sb_wadx = wadx;
                        sb_lane = in_addr[0];
                        sb_byte = in_wdata[7:0];
                        sb_rd   = in_rd;
                    end
                endcase
            end
        end
    end

    // Random output backpressure during the random phase.
    bit rand_phase = 0;
    always @(posedge clk) begin
        #1;
        if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request from posedge+1 until it is accepted; returns at posedge+1.
    task automatic issue(input logic [1:0] op, input logic [11:0] a,
                         input logic [15:0] d, input logic [2:0] rd);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = a;
        in_wdata = d;
        in_rd    = rd;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("issue_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (pops < n && k < 200) begin
            step();
            k++;
        end
        chk("wait_pops", pops, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [15:0] rdata;
    logic [11:0] raddr;
    logic [1:0]  rop;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
        in_rd = '0; out_ready = 1'b1; mem_clear = 1'b1;
        @(posedge clk); #1 mem_clear = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_wren", mem_WrEn, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_rdata", out_rdata, 16'h0000);
        chk("rst_out_rd", out_rd, 3'd0);
        chk("rst_out_is_load", out_is_load, 1'b0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        step();

        // Store word then load word at byte address 0x010 (word 0x008)
        issue(2'b10, 12'h010, 16'hBEEF, 3'd1);
        chk("sw_adx_lit", acc_adx, 11'h008);
        chk("sw_wren_lit", acc_wren, 1'b0);
        issue(2'b00, 12'h010, 16'h0000, 3'd2);
        chk("lw_adx_lit", acc_adx, 11'h008);
        wait_pops(2);
        chk("lw_data_lit", last_rdata, 16'hBEEF);
        chk("lw_is_load_lit", last_is_load, 1'b1);
        chk("lw_rd_lit", last_rd, 3'd2);

        // Byte store into the upper lane of 0x1234
        issue(2'b10, 12'h010, 16'h1234, 3'd3);
        issue(2'b11, 12'h011, 16'h00AB, 3'd4);
        chk("sb_first_wren_lit", acc_wren, 1'b1);
        @(negedge clk);
        chk("sb_second_wren_lit", mem_WrEn, 1'b0);
        chk("sb_second_ready_lit", in_ready, 1'b0);
        chk("sb_second_adx_lit", mem_adx, 11'h008);
        step();
        chk("sb_mem_lit", mem_arr[8], 16'hAB34);
        wait_pops(4);
        chk("sb_rd_lit", last_rd, 3'd4);
        chk("sb_is_load_lit", last_is_load, 1'b0);

        // Sign-extending byte loads
        issue(2'b10, 12'h010, 16'h80F0, 3'd5);
        issue(2'b01, 12'h010, 16'h0000, 3'd6);
        wait_pops(6);
        chk("lb_lo_lit", last_rdata, 16'hFFF0);
        issue(2'b01, 12'h011, 16'h0000, 3'd7);
        wait_pops(7);
        chk("lb_hi_lit", last_rdata, 16'hFF80);

        // Backpressure: full slot blocks acceptance until out_ready returns
        out_ready = 1'b0;
        issue(2'b00, 12'h010, 16'h0000, 3'd1);
        in_valid = 1'b1; in_op = 2'b00; in_addr = 12'h010; in_rd = 3'd2;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        step();
        out_ready = 1'b1;
        issue(2'b00, 12'h010, 16'h0000, 3'd2);
        wait_pops(8);
        chk("bp_first_rd_lit", last_rd, 3'd1);
        wait_pops(9);
        chk("bp_second_rd_lit", last_rd, 3'd2);
        chk("bp_second_data_lit", last_rdata, 16'h80F0);

        // Reset while the byte store is in its write cycle
        issue(2'b10, 12'h020, 16'h5555, 3'd3);
        issue(2'b11, 12'h020, 16'h0077, 3'd4);
        #2 rst = 1'b0;
        #1;
        chk("rst_rmw_wren", mem_WrEn, 1'b1);
        chk("rst_rmw_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        chk("rst_rmw_mem_lit", mem_arr[16], 16'h5555);
        chk("rst_rmw_out_valid_after", out_valid, 1'b0);
        step();
        issue(2'b00, 12'h020, 16'h0000, 3'd5);
        wait_pops(11);
        chk("rst_rmw_load_lit", last_rdata, 16'h5555);

        // Random mixed stream with random stalls
        rand_phase = 1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) step();
            rop   = 2'($urandom_range(0, 3));
            raddr = 12'($urandom_range(0, 15));
            rdata = 16'($urandom);
            issue(rop, raddr, rdata, 3'(i));
        end
        rand_phase = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (expq.size() == 0 && !sb_busy) break;
            step();
        end
        chk("drain_queue", expq.size(), 0);
        chk("pop_count_lit", pops, 211);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
